// File: rtl/pool1_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool1_stream_pkg
// Purpose  : Shared sizing helpers, default frame geometry and FSM state type
//            for the pool1 output streamer.
// Revision : 1.0 - initial release
// ============================================================================
package pool1_stream_pkg;

  localparam int NCHAN_DEF = 18;
  localparam int DIM_DEF   = 12;
  localparam int W_DEF     = 32;

  function automatic int calc_nwords(input int fbits, input int w);
    return (fbits + w - 1) / w;
  endfunction

  function automatic int calc_cnt_w(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

  localparam int FBITS  = NCHAN_DEF * DIM_DEF * DIM_DEF;
  localparam int NWORDS = calc_nwords(FBITS, W_DEF);
  localparam int CNT_W  = calc_cnt_w(NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/pool1_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : pool1_stream_tx
// Purpose  : Snapshots the parallel pool1 fmap bus and streams it out as
//            W-bit words over valid/ready, frame bit 0 in the word MSB.
// Options  : POOL1_STREAM_TX_PARITY_EN adds m_parity (even parity of m_data).
// Revision : 1.0 - initial release
// ============================================================================
module pool1_stream_tx #(
  parameter int NCHAN = 18,
  parameter int DIM   = 12,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [0:NCHAN*DIM*DIM-1] fmaps_in,
  output logic                     busy,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [W-1:0]             m_data,
  output logic                     m_last,
  output logic                     done
`ifdef POOL1_STREAM_TX_PARITY_EN
  ,
  output logic                     m_parity
`endif
);
  import pool1_stream_pkg::*;

  localparam int FRAME_BITS = NCHAN * DIM * DIM;
  localparam int N_WORDS    = calc_nwords(FRAME_BITS, W);
  localparam int CW         = calc_cnt_w(N_WORDS);
  localparam int SH_BITS    = N_WORDS * W;
  localparam int PAD_BITS   = SH_BITS - FRAME_BITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);

  tx_state_t          state_q;
  logic [CW-1:0]      cnt_q;
  logic [SH_BITS-1:0] shadow_q;
  logic               m_valid_q;
  logic               m_last_q;
  logic               done_q;
  logic [SH_BITS-1:0] cap_frame_d;
  logic               hs_d;

  // Frame bit 0 lands in the shadow MSB; zero padding fills the tail of the last word.
  generate
    if (PAD_BITS == 0) begin : g_nopad
      assign cap_frame_d = fmaps_in;
    end else begin : g_pad
      assign cap_frame_d = {fmaps_in, {PAD_BITS{1'b0}}};
    end
  endgenerate

  assign hs_d = m_valid_q & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shadow_q  <= cap_frame_d;
            cnt_q     <= '0;
            m_valid_q <= 1'b1;
            m_last_q  <= (N_WORDS == 1);
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (hs_d) begin
            if (cnt_q == CNT_LAST) begin
              done_q <= 1'b1;
              // A start on the final handshake chains the next frame with no bubble.
              if (start) begin
                shadow_q  <= cap_frame_d;
                cnt_q     <= '0;
                m_valid_q <= 1'b1;
                m_last_q  <= (N_WORDS == 1);
              end else begin
                shadow_q  <= shadow_q << W;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                state_q   <= IDLE;
              end
            end else begin
              shadow_q <= shadow_q << W;
              cnt_q    <= cnt_q + CW'(1);
              m_last_q <= (cnt_q == CNT_LAST - CW'(1));
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state_q == SEND);
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign done    = done_q;
  assign m_data  = shadow_q[SH_BITS-1 -: W];

`ifdef POOL1_STREAM_TX_PARITY_EN
  assign m_parity = ^m_data;
`endif

endmodule
`default_nettype wire
